// File: rtl/rggen_rice_register_access_control.sv
// Privilege/lock gated register wrapper around rggen_register_common, with a
// per-transaction fault recorder. Carries the minimal rggen package/interfaces it builds on.

package rggen_rtl_pkg;
  typedef enum logic [1:0] {
    RGGEN_POSTED_WRITE = 2'b01,
    RGGEN_READ         = 2'b10,
    RGGEN_WRITE        = 2'b11
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;
endpackage

interface rggen_register_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int VALUE_WIDTH   = BUS_WIDTH
);
  import rggen_rtl_pkg::*;
  logic                     valid;
  rggen_access              access;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [BUS_WIDTH-1:0]     strobe;
  logic                     active;
  logic                     ready;
  rggen_status              status;
  logic [BUS_WIDTH-1:0]     read_data;
  logic [VALUE_WIDTH-1:0]   value;

  modport host (
    output valid, access, address, write_data, strobe,
    input  active, ready, status, read_data, value
  );
  modport register (
    input  valid, access, address, write_data, strobe,
    output active, ready, status, read_data, value
  );
endinterface

interface rggen_bit_field_if #(
  parameter int WIDTH = 32
);
  logic             read_valid;
  logic             write_valid;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] read_data;

  modport register (
    output read_valid, write_valid, write_data, mask,
    input  value, read_data
  );
  modport bit_field (
    input  read_valid, write_valid, write_data, mask,
    output value, read_data
  );
endinterface

module rggen_register_common
  import rggen_rtl_pkg::*;
#(
  parameter bit                     READABLE       = 1'b1,
  parameter bit                     WRITABLE       = 1'b1,
  parameter int                     ADDRESS_WIDTH  = 8,
  parameter bit [ADDRESS_WIDTH-1:0] OFFSET_ADDRESS = '0,
  parameter int                     BUS_WIDTH      = 32,
  parameter int                     DATA_WIDTH     = BUS_WIDTH,
  parameter int                     VALUE_WIDTH    = BUS_WIDTH
)(
  rggen_register_if.register  register_if,
  input  logic                i_additional_match,
  rggen_bit_field_if.register bit_field_if
);
  localparam int BYTES = BUS_WIDTH / 8;
  localparam int WORDS = DATA_WIDTH / BUS_WIDTH;

  logic [WORDS-1:0]      match;
  logic                  is_read;
  logic                  is_write;
  logic                  active;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] wmask;
  logic [BUS_WIDTH-1:0]  rdata;

  for (genvar i = 0; i < WORDS; i++) begin : g_match
    assign match[i] = register_if.address == ADDRESS_WIDTH'(OFFSET_ADDRESS + i * BYTES);
  end

  assign is_read  = register_if.access == RGGEN_READ;
  assign is_write = register_if.access inside {RGGEN_WRITE, RGGEN_POSTED_WRITE};
  assign active   = register_if.valid && (|match) && i_additional_match &&
                    ((READABLE && is_read) || (WRITABLE && is_write));

  // Bus word is replicated across the register; only the addressed word gets a mask.
  always_comb begin
    wdata = '0;
    wmask = '0;
    rdata = '0;
    for (int i = 0; i < WORDS; i++) begin
      wdata[i*BUS_WIDTH+:BUS_WIDTH] = register_if.write_data;
      if (match[i]) begin
        wmask[i*BUS_WIDTH+:BUS_WIDTH] = register_if.strobe;
        rdata = rdata | bit_field_if.read_data[i*BUS_WIDTH+:BUS_WIDTH];
      end
    end
  end

  assign register_if.active    = active;
  assign register_if.ready     = active;
  assign register_if.status    = RGGEN_OKAY;
  assign register_if.read_data = (active && is_read) ? rdata : '0;
  assign register_if.value     = VALUE_WIDTH'(bit_field_if.value);

  assign bit_field_if.read_valid  = active && is_read;
  assign bit_field_if.write_valid = active && is_write;
  assign bit_field_if.write_data  = wdata;
  assign bit_field_if.mask        = wmask;
endmodule

module rggen_rice_register_access_control
  import rggen_rtl_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH       = 8,
  parameter bit [ADDRESS_WIDTH-1:0] OFFSET_ADDRESS      = '0,
  parameter int                     BUS_WIDTH           = 32,
  parameter int                     DATA_WIDTH          = BUS_WIDTH,
  parameter int                     VALUE_WIDTH         = BUS_WIDTH,
  parameter int                     PRIVILEGE_WIDTH     = 2,
  parameter int                     READ_MIN_PRIVILEGE  = 0,
  parameter int                     WRITE_MIN_PRIVILEGE = 3,
  parameter bit                     LOCKABLE            = 1'b1,
  parameter int                     FAULT_COUNT_WIDTH   = 8
)(
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [PRIVILEGE_WIDTH-1:0]   i_privilege,
  input  logic                         i_write_enable,
  input  logic                         i_read_enable,
  input  logic                         i_lock,
  input  logic                         i_fault_clear,
  output logic                         o_locked,
  output logic                         o_fault,
  output logic                         o_fault_write,
  output logic [FAULT_COUNT_WIDTH-1:0] o_fault_count,
  rggen_register_if.register           register_if,
  rggen_bit_field_if.register          bit_field_if
);
  localparam int BYTES = BUS_WIDTH / 8;
  localparam int WORDS = DATA_WIDTH / BUS_WIDTH;
  localparam int PW1   = PRIVILEGE_WIDTH + 1;

  if ((READ_MIN_PRIVILEGE >= 2**PRIVILEGE_WIDTH) ||
      (WRITE_MIN_PRIVILEGE >= 2**PRIVILEGE_WIDTH) ||
      (FAULT_COUNT_WIDTH < 1) ||
      (DATA_WIDTH % BUS_WIDTH != 0)) begin : g_param_error
    $error("rggen_rice_register_access_control: illegal parameter combination");
  end

  typedef enum logic {UNLOCKED, LOCKED}    lock_state_e;
  typedef enum logic {FAULT_IDLE, FAULT_HELD} fault_state_e;

  lock_state_e                  lock_state_q, lock_state_d;
  fault_state_e                 fault_state_q, fault_state_d;
  logic                         fault_q, fault_d;
  logic                         fault_write_q, fault_write_d;
  logic [FAULT_COUNT_WIDTH-1:0] fault_count_q, fault_count_d;

  logic [WORDS-1:0] addr_match;
  logic             hit;
  logic             is_read;
  logic             is_write;
  logic [PW1-1:0]   priv_plus1;
  logic             read_priv_ok;
  logic             write_priv_ok;
  logic             grant;
  logic             fault;

  for (genvar i = 0; i < WORDS; i++) begin : g_hit
    assign addr_match[i] = register_if.address == ADDRESS_WIDTH'(OFFSET_ADDRESS + i * BYTES);
  end

  assign hit      = register_if.valid && (|addr_match);
  assign is_read  = register_if.access == RGGEN_READ;
  assign is_write = register_if.access inside {RGGEN_WRITE, RGGEN_POSTED_WRITE};

  // priv >= min expressed as priv+1 > min so a zero minimum is not a constant compare.
  assign priv_plus1    = {1'b0, i_privilege} + PW1'(1);
  assign read_priv_ok  = priv_plus1 > PW1'(READ_MIN_PRIVILEGE);
  assign write_priv_ok = priv_plus1 > PW1'(WRITE_MIN_PRIVILEGE);

  assign grant = (is_write && i_write_enable && write_priv_ok && (lock_state_q == UNLOCKED)) ||
                 (is_read  && i_read_enable  && read_priv_ok);
  assign fault = hit && !grant;

  rggen_register_common #(
    .READABLE       (1'b1),
    .WRITABLE       (1'b1),
    .ADDRESS_WIDTH  (ADDRESS_WIDTH),
    .OFFSET_ADDRESS (OFFSET_ADDRESS),
    .BUS_WIDTH      (BUS_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH),
    .VALUE_WIDTH    (VALUE_WIDTH)
  ) u_register_common (
    .register_if        (register_if),
    .i_additional_match (grant),
    .bit_field_if       (bit_field_if)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_state_q  <= UNLOCKED;
      fault_state_q <= FAULT_IDLE;
      fault_q       <= 1'b0;
      fault_write_q <= 1'b0;
      fault_count_q <= '0;
    end else begin
      lock_state_q  <= lock_state_d;
      fault_state_q <= fault_state_d;
      fault_q       <= fault_d;
      fault_write_q <= fault_write_d;
      fault_count_q <= fault_count_d;
    end
  end

  always_comb begin
    lock_state_d = lock_state_q;
    case (lock_state_q)
      UNLOCKED: if (LOCKABLE && i_lock) lock_state_d = LOCKED;
      LOCKED:   lock_state_d = LOCKED;
      default:  lock_state_d = UNLOCKED;
    endcase
  end

  // A transaction held valid across cycles is recorded once; HELD waits for valid to drop.
  always_comb begin
    fault_state_d = fault_state_q;
    fault_d       = 1'b0;
    fault_write_d = fault_write_q;
    fault_count_d = fault_count_q;
    case (fault_state_q)
      FAULT_IDLE: begin
        if (fault) begin
          fault_state_d = FAULT_HELD;
          fault_d       = 1'b1;
          fault_write_d = is_write;
        end
      end
      FAULT_HELD: if (!register_if.valid) fault_state_d = FAULT_IDLE;
      default:    fault_state_d = FAULT_IDLE;
    endcase
    if (i_fault_clear)
      fault_count_d = '0;
    else if (fault_d && !(&fault_count_q))
      fault_count_d = fault_count_q + FAULT_COUNT_WIDTH'(1);
  end

  assign o_locked      = lock_state_q == LOCKED;
  assign o_fault       = fault_q;
  assign o_fault_write = fault_write_q;
  assign o_fault_count = fault_count_q;
endmodule

// File: tb/tb_rggen_rice_register_access_control.sv
// Scoreboard bench: bus responses queued at drive time and popped per cycle,
// fault/lock outputs compared against a cycle model after every clock edge.
module tb_rggen_rice_register_access_control;
  import rggen_rtl_pkg::*;

  localparam int         AW  = 8;
  localparam int         BW  = 32;
  localparam int         DW  = 64;
  localparam int         FCW = 2;
  localparam logic [7:0] OFS = 8'h10;

  typedef struct {
    logic        ready;
    logic [31:0] rdata;
  } resp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1:0]     priv;
  logic           wen, ren, lock, fclr;
  logic           locked, fault, fault_write;
  logic [FCW-1:0] fault_count;
  logic [DW-1:0]  fld;

  int    checks = 0;
  int    passes = 0;
  resp_t sb_q[$];

  logic        m_lock, m_held, m_fault, m_fw;
  logic [1:0]  m_cnt;
  logic [31:0] shadow [2];

  rggen_register_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .VALUE_WIDTH(DW)) rif();
  rggen_bit_field_if #(.WIDTH(DW)) bif();

  always #5 clk = ~clk;

  rggen_rice_register_access_control #(
    .ADDRESS_WIDTH       (AW),
    .OFFSET_ADDRESS      (OFS),
    .BUS_WIDTH           (BW),
    .DATA_WIDTH          (DW),
    .VALUE_WIDTH         (DW),
    .PRIVILEGE_WIDTH     (2),
    .READ_MIN_PRIVILEGE  (0),
    .WRITE_MIN_PRIVILEGE (3),
    .LOCKABLE            (1'b1),
    .FAULT_COUNT_WIDTH   (FCW)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_privilege    (priv),
    .i_write_enable (wen),
    .i_read_enable  (ren),
    .i_lock         (lock),
    .i_fault_clear  (fclr),
    .o_locked       (locked),
    .o_fault        (fault),
    .o_fault_write  (fault_write),
    .o_fault_count  (fault_count),
    .register_if    (rif),
    .bit_field_if   (bif)
  );

  // Plain read/write bit field behind the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fld <= '0;
    else if (bif.write_valid) fld <= (fld & ~bif.mask) | (bif.write_data & bif.mask);
  end
  assign bif.value     = fld;
  assign bif.read_data = fld;

  function automatic logic grant_of(input rggen_access acc, input logic [7:0] addr);
    logic in_range, wr;
    in_range = (addr == OFS) || (addr == OFS + 8'd4);
    wr       = (acc == RGGEN_WRITE) || (acc == RGGEN_POSTED_WRITE);
    return in_range && ((wr && wen && priv == 2'd3 && !m_lock) || (acc == RGGEN_READ && ren));
  endfunction

  task automatic model_reset();
    m_lock = 0; m_held = 0; m_fault = 0; m_fw = 0; m_cnt = 0;
    shadow[0] = '0; shadow[1] = '0;
  endtask

  // One clock: check the bus response, advance the model, check registered outputs.
  task automatic step();
    resp_t e;
    logic  hit, g, wr, flt, rec;
    int    w;
    @(negedge clk);
    if (rif.valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_underflow: response seen with no expectation queued");
      end else begin
        e = sb_q.pop_front();
        if (rif.ready !== e.ready)
          $display("FAIL ready: got %0b want %0b (addr %0h)", rif.ready, e.ready, rif.address);
        else passes++;
        checks++;
        if (rif.read_data !== e.rdata)
          $display("FAIL read_data: got %0h want %0h (addr %0h)", rif.read_data, e.rdata, rif.address);
        else passes++;
      end
    end
    wr  = (rif.access == RGGEN_WRITE) || (rif.access == RGGEN_POSTED_WRITE);
    w   = (rif.address == OFS + 8'd4) ? 1 : 0;
    hit = rif.valid && ((rif.address == OFS) || (rif.address == OFS + 8'd4));
    g   = hit && grant_of(rif.access, rif.address);
    flt = hit && !g;
    rec = flt && !m_held;
    if (g && wr) shadow[w] = (shadow[w] & ~rif.strobe) | (rif.write_data & rif.strobe);
    m_held  = m_held ? rif.valid : flt;
    m_fault = rec;
    if (rec) m_fw = wr;
    if (fclr) m_cnt = 2'd0;
    else if (rec && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
    if (lock) m_lock = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (fault !== m_fault) $display("FAIL o_fault: got %0b want %0b", fault, m_fault);
    else passes++;
    checks++;
    if (fault_write !== m_fw) $display("FAIL o_fault_write: got %0b want %0b", fault_write, m_fw);
    else passes++;
    checks++;
    if (fault_count !== m_cnt) $display("FAIL o_fault_count: got %0d want %0d", fault_count, m_cnt);
    else passes++;
    checks++;
    if (locked !== m_lock) $display("FAIL o_locked: got %0b want %0b", locked, m_lock);
    else passes++;
  endtask

  // Transaction held valid for `hold` cycles; lock/clear pulses apply to the first cycle only.
  task automatic txn(input rggen_access acc, input logic [7:0] addr,
                     input logic [31:0] wd, input int hold);
    resp_t e;
    rif.valid = 1'b1; rif.access = acc; rif.address = addr;
    rif.write_data = wd; rif.strobe = '1;
    for (int c = 0; c < hold; c++) begin
      e.ready = grant_of(acc, addr);
      e.rdata = (e.ready && acc == RGGEN_READ) ? shadow[(addr == OFS + 8'd4) ? 1 : 0] : 32'h0;
      sb_q.push_back(e);
      step();
      lock = 1'b0;
      fclr = 1'b0;
    end
    rif.valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; priv = 0; wen = 0; ren = 0; lock = 0; fclr = 0;
    rif.valid = 0; rif.access = RGGEN_READ; rif.address = '0; rif.write_data = '0; rif.strobe = '0;
    model_reset();
    #2;
    checks++; if (fault !== 1'b0) $display("FAIL reset_fault: got %0b want 0", fault); else passes++;
    checks++; if (fault_write !== 1'b0) $display("FAIL reset_fault_write: got %0b want 0", fault_write); else passes++;
    checks++; if (fault_count !== '0) $display("FAIL reset_count: got %0d want 0", fault_count); else passes++;
    checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %0b want 0", locked); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_granted();
    priv = 2'd3; wen = 1; ren = 1;
    txn(RGGEN_WRITE, OFS, 32'hA5A5_0001, 1);
    checks++;
    if (bif.value[31:0] !== 32'hA5A5_0001) $display("FAIL field_after_write: got %0h want a5a50001", bif.value[31:0]);
    else passes++;
    txn(RGGEN_READ, OFS, 32'h0, 1);
    checks++;
    if (fault_count !== 2'd0) $display("FAIL granted_count: got %0d want 0", fault_count); else passes++;
  endtask

  task automatic test_boundary();
    priv = 2'd3;
    txn(RGGEN_WRITE, OFS + 8'd4, 32'h1234_5678, 1);
    txn(RGGEN_READ,  OFS + 8'd4, 32'h0, 1);
    checks++;
    if (bif.value[63:32] !== 32'h1234_5678) $display("FAIL upper_word: got %0h want 12345678", bif.value[63:32]);
    else passes++;
    priv = 2'd1;
    txn(RGGEN_WRITE, OFS + 8'd8, 32'hFFFF_FFFF, 1);
    txn(RGGEN_WRITE, OFS + 8'd2, 32'hFFFF_FFFF, 1);
    txn(RGGEN_READ,  OFS - 8'd4, 32'h0, 1);
    checks++;
    if (fault_count !== 2'd0) $display("FAIL out_of_range_count: got %0d want 0", fault_count); else passes++;
  endtask

  task automatic test_priv_fault();
    priv = 2'd1;
    txn(RGGEN_WRITE, OFS, 32'hDEAD_BEEF, 4);
    checks++;
    if (fault_count !== 2'd1) $display("FAIL held_fault_count: got %0d want 1", fault_count); else passes++;
    checks++;
    if (fault_write !== 1'b1) $display("FAIL held_fault_write: got %0b want 1", fault_write); else passes++;
    checks++;
    if (bif.value[31:0] !== 32'hA5A5_0001) $display("FAIL field_untouched: got %0h want a5a50001", bif.value[31:0]);
    else passes++;
  endtask

  task automatic test_lock();
    priv = 2'd3; lock = 1'b1;
    txn(RGGEN_WRITE, OFS, 32'h0000_00FF, 1);
    checks++;
    if (bif.value[31:0] !== 32'h0000_00FF) $display("FAIL write_with_lock_edge: got %0h want ff", bif.value[31:0]);
    else passes++;
    txn(RGGEN_POSTED_WRITE, OFS, 32'h0000_0001, 1);
    checks++;
    if (fault_count !== 2'd2) $display("FAIL locked_write_count: got %0d want 2", fault_count); else passes++;
    priv = 2'd0;
    txn(RGGEN_READ, OFS, 32'h0, 1);
    checks++;
    if (locked !== 1'b1) $display("FAIL lock_sticky: got %0b want 1", locked); else passes++;
  endtask

  task automatic test_clear_collision();
    ren = 1'b0; fclr = 1'b1;
    txn(RGGEN_READ, OFS, 32'h0, 1);
    checks++;
    if (fault_count !== 2'd0) $display("FAIL clear_wins: got %0d want 0", fault_count); else passes++;
  endtask

  task automatic test_saturate();
    ren = 1'b0;
    for (int i = 0; i < 5; i++) txn(RGGEN_READ, OFS + 8'd4, 32'h0, 1);
    checks++;
    if (fault_count !== 2'd3) $display("FAIL saturate: got %0d want 3", fault_count); else passes++;
    checks++;
    if (fault_write !== 1'b0) $display("FAIL read_fault_type: got %0b want 0", fault_write); else passes++;
  endtask

  task automatic test_reset_held();
    resp_t e;
    fclr = 1'b1;
    step();
    fclr = 1'b0;
    priv = 2'd0;
    rif.valid = 1'b1; rif.access = RGGEN_WRITE; rif.address = OFS; rif.write_data = 32'h5; rif.strobe = '1;
    for (int c = 0; c < 2; c++) begin
      e.ready = grant_of(RGGEN_WRITE, OFS); e.rdata = 32'h0;
      sb_q.push_back(e);
      step();
    end
    checks++;
    if (fault_count !== 2'd1) $display("FAIL pre_reset_count: got %0d want 1", fault_count); else passes++;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (fault !== 1'b0) $display("FAIL midreset_fault: got %0b want 0", fault); else passes++;
    checks++; if (fault_count !== '0) $display("FAIL midreset_count: got %0d want 0", fault_count); else passes++;
    checks++; if (fault_write !== 1'b0) $display("FAIL midreset_fault_write: got %0b want 0", fault_write); else passes++;
    checks++; if (locked !== 1'b0) $display("FAIL midreset_locked: got %0b want 0", locked); else passes++;
    rst_n = 1'b1;
    e.ready = grant_of(RGGEN_WRITE, OFS); e.rdata = 32'h0;
    sb_q.push_back(e);
    step();
    rif.valid = 1'b0;
    step();
    checks++;
    if (fault_count !== 2'd1) $display("FAIL refault_after_reset: got %0d want 1", fault_count); else passes++;
  endtask

  initial begin
    test_reset();
    test_write_granted();
    test_boundary();
    test_priv_fault();
    test_lock();
    test_clear_collision();
    test_saturate();
    test_reset_held();
    checks++;
    if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d want 0", sb_q.size()); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
